// File: rtl/servo_ramp_scheduler.sv
// -----------------------------------------------------------------------------
// servo_ramp_scheduler
//
// Sequences the angle command handed to the servo PWM generator so the servo
// never jumps. Sign-magnitude commands arrive over a valid/ready handshake and
// are clamped to MAX_MAG. A registered position is then slewed toward the
// target by at most STEP units per servo frame. After arrival the block waits
// SETTLE_FRAMES frames and pulses done.
//
// Parameters:
//   FRAME_CYCLES   clocks per servo frame
//   STEP           maximum magnitude change per frame (1..255)
//   MAX_MAG        command magnitude clamp
//   SETTLE_FRAMES  frames to wait after arrival before done (0..255)
//
// Ports:
//   clk             system clock
//   rst_a_n         asynchronous active-low reset
//   cmd_valid       command present
//   cmd_angle       command magnitude [15:0]
//   cmd_negative    command sign (1 = negative)
//   cmd_ready       command can be accepted (= ~hold)
//   hold            freeze: no steps, no settle counting, no accepts
//   absolute_angle  current position magnitude, registered [15:0]
//   is_negative     current position sign, registered, never set for zero
//   busy            ramping or settling
//   frame_tick      one-cycle pulse at frame end
//   done            one-cycle pulse: target reached and settled
// -----------------------------------------------------------------------------
module servo_ramp_scheduler #(
    parameter int          FRAME_CYCLES  = 1_000_000,
    parameter int          STEP          = 4,
    parameter logic [15:0] MAX_MAG       = 16'h01FF,
    parameter int          SETTLE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_a_n,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_angle,
    input  logic        cmd_negative,
    output logic        cmd_ready,
    input  logic        hold,
    output logic [15:0] absolute_angle,
    output logic        is_negative,
    output logic        busy,
    output logic        frame_tick,
    output logic        done
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RAMP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    localparam logic signed [17:0] STEP_WIDE   = 18'(STEP);
    localparam logic signed [17:0] STEP_WIDE_N = -18'(STEP);
    localparam logic signed [16:0] STEP_POS    = 17'(STEP);
    localparam logic [8:0]         SETTLE_LAST = 9'(SETTLE_FRAMES);

    logic [CNT_W-1:0]   frame_cnt_reg;
    logic signed [16:0] pos_reg, pos_next;
    logic signed [16:0] tgt_reg, tgt_next;
    logic [7:0]         settle_reg, settle_next;
    logic [1:0]         state_reg, state_next;
    logic               done_reg, done_next;
    logic [15:0]        mag_reg, mag_next;
    logic               neg_reg;

    logic [15:0]        clamp_mag;
    logic signed [16:0] cmd_tgt;
    logic signed [17:0] diff;
    logic               diff_small;
    logic signed [16:0] pos_step;
    logic [8:0]         settle_inc;
    logic               accept;
    logic               step_en;

    assign cmd_ready      = ~hold;
    assign accept         = cmd_valid & ~hold;
    assign frame_tick     = (frame_cnt_reg == FRAME_LAST);
    assign step_en        = frame_tick & ~hold;
    assign busy           = (state_reg != ST_IDLE);
    assign done           = done_reg;
    assign absolute_angle = mag_reg;
    assign is_negative    = neg_reg;

    // Command conversion: clamp, fold -0 into +0, then two's complement.
    always_comb begin
        clamp_mag = (cmd_angle > MAX_MAG) ? MAX_MAG : cmd_angle;
        if (cmd_negative && (clamp_mag != 16'd0)) begin
            cmd_tgt = -$signed({1'b0, clamp_mag});
        end else begin
            cmd_tgt = $signed({1'b0, clamp_mag});
        end
    end

    // Distance to target in 18 bits so the full 17-bit range never overflows.
    always_comb begin
        diff       = {tgt_reg[16], tgt_reg} - {pos_reg[16], pos_reg};
        diff_small = (diff <= STEP_WIDE) && (diff >= STEP_WIDE_N);
        pos_step   = diff[17] ? (pos_reg - STEP_POS) : (pos_reg + STEP_POS);
        settle_inc = {1'b0, settle_reg} + 9'd1;
    end

    always_comb begin
        pos_next    = pos_reg;
        tgt_next    = tgt_reg;
        settle_next = settle_reg;
        state_next  = state_reg;
        done_next   = 1'b0;

        case (state_reg)
            ST_RAMP: begin
                if (step_en) begin
                    if (diff_small) begin
                        pos_next    = tgt_reg;
                        settle_next = 8'd0;
                        if (SETTLE_FRAMES == 0) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_SETTLE;
                        end
                    end else begin
                        pos_next = pos_step;
                    end
                end
            end
            ST_SETTLE: begin
                if (step_en) begin
                    settle_next = settle_inc[7:0];
                    if (settle_inc == SETTLE_LAST) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // An accept overrides the state decision made above. A coincident
        // step still moves pos toward the old target, but a completing step
        // no longer ends the ramp: the new target takes over next frame.
        if (accept) begin
            tgt_next = cmd_tgt;
            if (cmd_tgt == pos_reg) begin
                // Already there: hold position so a coincident step cannot
                // move us away from the target we just declared reached.
                pos_next   = pos_reg;
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end else begin
                state_next = ST_RAMP;
                done_next  = 1'b0;
            end
        end
    end

    // Output magnitude from the next position so outputs track pos exactly.
    always_comb begin
        if (pos_next[16]) begin
            mag_next = ~pos_next[15:0] + 16'd1;
        end else begin
            mag_next = pos_next[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            frame_cnt_reg <= '0;
            pos_reg       <= '0;
            tgt_reg       <= '0;
            settle_reg    <= '0;
            state_reg     <= ST_IDLE;
            done_reg      <= 1'b0;
            mag_reg       <= '0;
            neg_reg       <= 1'b0;
        end else begin
            frame_cnt_reg <= frame_tick ? '0 : frame_cnt_reg + 1'b1;
            pos_reg       <= pos_next;
            tgt_reg       <= tgt_next;
            settle_reg    <= settle_next;
            state_reg     <= state_next;
            done_reg      <= done_next;
            mag_reg       <= mag_next;
            neg_reg       <= pos_next[16];
        end
    end

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
module tb_servo_ramp_scheduler;

    localparam int FC = 100;

    logic        clk = 1'b0;
    logic        rst_a_n;
    logic        cmd_valid;
    logic [15:0] cmd_angle;
    logic        cmd_negative;
    logic        cmd_ready;
    logic        hold;
    logic [15:0] absolute_angle;
    logic        is_negative;
    logic        busy;
    logic        frame_tick;
    logic        done;

    int pass_cnt   = 0;
    int total_cnt  = 0;
    int cyc        = 0;
    int done_cnt   = 0;
    int tick_count = 0;
    int mpos       = 0;
    int exp_q[$];

    servo_ramp_scheduler #(
        .FRAME_CYCLES (FC),
        .STEP         (4),
        .MAX_MAG      (16'd511),
        .SETTLE_FRAMES(2)
    ) dut (
        .clk           (clk),
        .rst_a_n       (rst_a_n),
        .cmd_valid     (cmd_valid),
        .cmd_angle     (cmd_angle),
        .cmd_negative  (cmd_negative),
        .cmd_ready     (cmd_ready),
        .hold          (hold),
        .absolute_angle(absolute_angle),
        .is_negative   (is_negative),
        .busy          (busy),
        .frame_tick    (frame_tick),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (done === 1'b1) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Advance to just after the next frame_tick edge.
    task automatic tick();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 2 * FC) begin
            cycle();
            n++;
        end
        if (frame_tick !== 1'b1) check("tick_timeout", frame_tick, 1);
        cycle();
        tick_count++;
    endtask

    // Reference ramp: push every per-frame position from mpos to target.
    task automatic push_ramp(input int target);
        int p;
        int d;
        p = mpos;
        while (p != target) begin
            d = target - p;
            if (d <= 4 && d >= -4) p = target;
            else if (d > 0)        p = p + 4;
            else                   p = p - 4;
            exp_q.push_back(p);
        end
        mpos = target;
    endtask

    function automatic int clamp_cmd(input int angle, input logic neg);
        int t;
        t = (angle > 511) ? 511 : angle;
        return neg ? -t : t;
    endfunction

    task automatic send(input int angle, input logic neg);
        cmd_valid    = 1'b1;
        cmd_angle    = 16'(angle);
        cmd_negative = neg;
        cycle();
        cmd_valid    = 1'b0;
        push_ramp(clamp_cmd(angle, neg));
    endtask

    task automatic check_pos(input string tag, input int e);
        check({tag, "_mag"}, absolute_angle, (e < 0) ? -e : e);
        check({tag, "_neg"}, is_negative, (e < 0) ? 1 : 0);
    endtask

    task automatic run_ramp(input string tag);
        int e;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check_pos(tag, e);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_nodone"}, done, 0);
        end
    endtask

    task automatic settle_and_done(input string tag);
        tick();
        check({tag, "_settle1_done"}, done, 0);
        check({tag, "_settle1_busy"}, busy, 1);
        tick();
        check({tag, "_done"}, done, 1);
        cycle();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n;
        int dc;
        int e;

        rst_a_n      = 1'b0;
        hold         = 1'b0;
        cmd_valid    = 1'b0;
        cmd_angle    = 16'd0;
        cmd_negative = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a_n = 1'b1;

        // Reset state
        check("rst_mag", absolute_angle, 0);
        check("rst_neg", is_negative, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);

        // Frame tick cadence
        n = 0;
        while (frame_tick !== 1'b1 && n < 3 * FC) begin cycle(); n++; end
        check("tick1_cycle", cyc, 99);
        cycle();
        check("tick1_pulse", frame_tick, 0);
        n = 0;
        while (frame_tick !== 1'b1 && n < 3 * FC) begin cycle(); n++; end
        check("tick2_cycle", cyc, 199);
        cycle();

        // -0 at position 0: target equals pos, immediate done, stays idle
        send(0, 1'b1);
        check("neg0_done", done, 1);
        check("neg0_busy", busy, 0);
        check("neg0_sign", is_negative, 0);
        cycle();
        check("neg0_pulse", done, 0);

        // +10 from 0
        send(10, 1'b0);
        check("p10_busy", busy, 1);
        tick_count = 0;
        run_ramp("p10");
        settle_and_done("p10");
        check("p10_ticks", tick_count, 5);

        // +6 then -5: zero crossing
        send(6, 1'b0);
        run_ramp("p6");
        settle_and_done("p6");
        send(5, 1'b1);
        run_ramp("m5");
        settle_and_done("m5");

        // Clamp
        send(16'hFFFF, 1'b0);
        run_ramp("clamp");
        settle_and_done("clamp");
        check("clamp_final", absolute_angle, 511);

        // Hold for 3 frames mid-ramp; a command offered during hold is ignored
        send(480, 1'b0);
        tick_count = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            check_pos("hold_pre", e);
        end
        hold         = 1'b1;
        cmd_valid    = 1'b1;
        cmd_angle    = 16'd100;
        cmd_negative = 1'b0;
        #1;
        check("hold_ready", cmd_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pos("hold_frozen", e);
            check("hold_busy", busy, 1);
        end
        cmd_valid = 1'b0;
        hold      = 1'b0;
        #1;
        check("hold_release_ready", cmd_ready, 1);
        run_ramp("hold_post");
        settle_and_done("hold");
        check("hold_ticks", tick_count, 13);

        // New command during SETTLE aborts it without done
        send(490, 1'b0);
        run_ramp("pre_abort");
        tick();
        check("abort_settle_done", done, 0);
        dc = done_cnt;
        send(470, 1'b0);
        check("abort_busy", busy, 1);
        run_ramp("abort");
        check("abort_no_done", done_cnt, dc);
        settle_and_done("abort");

        // Accept coincident with a completing tick
        send(474, 1'b0);
        n = 0;
        while (frame_tick !== 1'b1 && n < 2 * FC) begin cycle(); n++; end
        check("coin_tick_seen", frame_tick, 1);
        cmd_valid    = 1'b1;
        cmd_angle    = 16'd460;
        cmd_negative = 1'b0;
        cycle();
        cmd_valid = 1'b0;
        e = exp_q.pop_front();
        check_pos("coin_step", e);
        check("coin_busy", busy, 1);
        check("coin_nodone", done, 0);
        push_ramp(460);
        run_ramp("coin");
        settle_and_done("coin");
        check("coin_final", absolute_angle, 460);

        // Asynchronous reset mid-ramp
        send(100, 1'b1);
        tick();
        tick();
        #2;
        rst_a_n = 1'b0;
        #1;
        check("arst_mag", absolute_angle, 0);
        check("arst_neg", is_negative, 0);
        check("arst_busy", busy, 0);
        exp_q.delete();
        mpos = 0;
        @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        n = 0;
        while (frame_tick !== 1'b1 && n < 3 * FC) begin cycle(); n++; end
        check("arst_tick_cycle", cyc, 99);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/servo_ramp_scheduler.md
# servo_ramp_scheduler

Sequences the angle command fed to the servo PWM generator so the servo never jumps. Accepts sign-magnitude angle commands over a valid/ready handshake and slews a registered position toward the target by at most STEP units per 20 ms servo frame. After arrival it waits a settle interval and then pulses `done`. Sits between the accelerometer/command logic and the PWM generator, and drives its `absolute_angle`/`is_negative` inputs.

## Interface
- `FRAME_CYCLES`, 1_000_000: clocks per servo frame (20 ms at 50 MHz).
- `STEP`, 4: maximum magnitude change per frame, 1..255.
- `MAX_MAG`, 16'h01FF: command magnitude clamp.
- `SETTLE_FRAMES`, 8: frames to wait after arrival before `done`, 0..255.

Ports:
- `clk`  in  1  system clock.
- `rst_a_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_angle`  in  16  command magnitude.
- `cmd_negative`  in  1  command sign (1 = negative).
- `cmd_ready`  out  1  command can be accepted; equals `~hold`.
- `hold`  in  1  freeze: no position steps, no settle counting, no accepts.
- `absolute_angle`  out  16  current position magnitude, registered.
- `is_negative`  out  1  current position sign, registered; never 1 when magnitude is 0.
- `busy`  out  1  state is RAMP or SETTLE.
- `frame_tick`  out  1  one-cycle pulse at frame end.
- `done`  out  1  one-cycle pulse: target reached and settled.

## Operation
- Internal state: signed 17-bit `pos` and `tgt` (two's complement of the sign-magnitude value), 8-bit settle counter, FSM {IDLE, RAMP, SETTLE}.
- Frame counter runs freely from 0 to FRAME_CYCLES-1 and wraps. `frame_tick`=1 when counter = FRAME_CYCLES-1. `hold` does not stop the counter.
- Accept: `cmd_valid & cmd_ready`. The magnitude is clamped to MAX_MAG. A negative command with magnitude 0 becomes +0. The result is stored in `tgt` at that edge.
- Accept in any state:
  - If the clamped target equals `pos`, go to IDLE and pulse `done` the next cycle.
  - Otherwise go to RAMP. An accept during SETTLE aborts the settle with no `done`.
- RAMP step, on `frame_tick & ~hold`, using the registered `tgt`:
  - Compute diff = `tgt` − `pos` in 18 bits signed.
  - If |diff| ≤ STEP: `pos`←`tgt`, clear the settle counter, go to SETTLE. If SETTLE_FRAMES=0, go directly to IDLE and pulse `done`.
  - Otherwise `pos` ← `pos` ± STEP, toward `tgt`.
- SETTLE, on `frame_tick & ~hold`: increment the counter. When it reaches SETTLE_FRAMES, go to IDLE and pulse `done` for 1 cycle.
- An accept and a `frame_tick` in the same cycle: the step uses the old `tgt`, and the new `tgt` is used from the next frame. If the step would complete the ramp, the accept wins: the state stays RAMP.
- Zero crossing is handled in signed arithmetic. Outputs are derived from `pos` as magnitude = |pos| and sign = pos<0.

## Timing
- Reset values: `absolute_angle`=0, `is_negative`=0, `busy`=0, `frame_tick`=0, `done`=0, `cmd_ready`=1 when `hold`=0. Frame counter=0, FSM=IDLE, `tgt`=0.
- Reset asserted mid-ramp aborts immediately. The counter restarts at 0.
- `busy` rises on the cycle after accept.
- `absolute_angle`/`is_negative` change on the cycle after the `frame_tick` cycle.
- First `frame_tick` occurs FRAME_CYCLES cycles after reset release (counter = FRAME_CYCLES-1).
- Ramp of distance D takes ceil(D/STEP) ticks, then SETTLE_FRAMES ticks. `done` is asserted 1 cycle after the final tick edge.
- `done` and a new accept in the same cycle are legal. The accept is processed normally.

## Test plan
Bench uses FRAME_CYCLES=100, STEP=4, SETTLE_FRAMES=2, MAX_MAG=511.
- Reset release, no commands: outputs 0 and `cmd_ready`=1. `frame_tick` at cycles 99, 199, ….
- Command +10 from 0: positions 4, 8, 10 on successive ticks. Then 2 settle ticks, then a single `done`. `busy` is low after `done`.
- From +6, command −5 (`cmd_negative`=1): positions 2, −2 (mag 2, `is_negative`=1), −5. No −0 appears at any point.
- Command 16'hFFFF: target is clamped to 511. Ramp ends at `absolute_angle`=511.
- `hold`=1 for 3 frames mid-ramp: position frozen and `cmd_ready`=0. Ramp resumes after release, and the total tick count increases by 3.
- New command during SETTLE: no `done`, re-enter RAMP. Accept coincident with a completing tick: state stays RAMP and the new target is reached.
